// File: rtl/or_accumulator.sv
// or_accumulator: ORs accepted words into frames of up to FRAME_LEN words and holds each frame until delivered
module or_accumulator #(
  parameter int WIDTH     = 1,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       out_count
);
  localparam logic [7:0] FL = 8'(FRAME_LEN);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t           state;
  logic [WIDTH-1:0] acc, nacc;
  logic [7:0]       cnt, ncnt;
  logic             accept, close;
  // next accumulator/count and whether this cycle closes the frame; first word in IDLE loads rather than ORs
  always_comb begin
    in_ready = rst_n && (state != HOLD);
    accept   = in_valid && in_ready;
    nacc     = accept ? ((state == IDLE) ? in_data : (acc | in_data)) : acc;
    ncnt     = accept ? ((state == IDLE) ? 8'd1 : cnt + 8'd1) : cnt;
    close    = accept ? (ncnt == FL || flush) : (state == ACCUM && flush);
  end
  // frame state machine with registered frame outputs, held stable while in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (state == HOLD) begin
      if (out_ready) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        acc       <= '0;
        cnt       <= '0;
      end
    end else if (close) begin
      state     <= HOLD;
      out_valid <= 1'b1;
      out_data  <= nacc;
      out_count <= ncnt;
      acc       <= nacc;
      cnt       <= ncnt;
    end else if (accept) begin
      state <= ACCUM;
      acc   <= nacc;
      cnt   <= ncnt;
    end
  end
endmodule

// File: tb/tb_or_accumulator.sv
// tb_or_accumulator: scoreboard bench for or_accumulator (FRAME_LEN=4 and FRAME_LEN=1 instances)
module tb_or_accumulator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_in_valid = 1'b0, a_in_ready, a_flush = 1'b0, a_out_valid, a_out_ready = 1'b1;
  logic [7:0] a_in_data = '0, a_out_data, a_out_count;
  logic       b_in_valid = 1'b0, b_in_ready, b_flush = 1'b0, b_out_valid, b_out_ready = 1'b1;
  logic [7:0] b_in_data = '0, b_out_data, b_out_count;
  logic [15:0] qa[$], qb[$];
  int cmp = 0, bad = 0;

  or_accumulator #(.WIDTH(8), .FRAME_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_count(a_out_count));

  or_accumulator #(.WIDTH(8), .FRAME_LEN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_count(b_out_count));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor A: compare each delivered frame against the scoreboard
  always @(negedge clk) if (rst_n && a_out_valid && a_out_ready) begin
    if (qa.size() == 0) check("a_unexpected_frame", {a_out_data, a_out_count}, 16'hxxxx);
    else begin
      logic [15:0] e;
      e = qa.pop_front();
      check("a_frame_data", a_out_data, e[15:8]);
      check("a_frame_count", a_out_count, e[7:0]);
    end
  end

  // monitor B
  always @(negedge clk) if (rst_n && b_out_valid && b_out_ready) begin
    if (qb.size() == 0) check("b_unexpected_frame", {b_out_data, b_out_count}, 16'hxxxx);
    else begin
      logic [15:0] e;
      e = qb.pop_front();
      check("b_frame_data", b_out_data, e[15:8]);
      check("b_frame_count", b_out_count, e[7:0]);
    end
  end

  task automatic send_a(input logic [7:0] d, input logic fl);
    int n = 0;
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_flush    = fl;
    while (!a_in_ready && n < 50) begin step(); n++; end
    if (n == 50) check("a_send_timeout", 0, 1);
    step();
    a_in_valid = 1'b0;
    a_flush    = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    int n = 0;
    b_in_valid = 1'b1;
    b_in_data  = d;
    while (!b_in_ready && n < 50) begin
      b_out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    if (n == 50) check("b_send_timeout", 0, 1);
    b_out_ready = 1'($urandom_range(0, 1));
    step();
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (qa.size() != 0 && n < 50) begin step(); n++; end
    if (n == 50) check("a_drain_timeout", qa.size(), 0);
  endtask

  initial begin
    logic [7:0] words[10] = '{8'h11, 8'h22, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h3C, 8'hC3};
    #2;
    check("reset_in_ready", a_in_ready, 0);
    check("reset_out_valid", a_out_valid, 0);
    check("reset_out_data", a_out_data, 0);
    check("reset_out_count", a_out_count, 0);
    #10 rst_n = 1'b1;
    step();
    check("in_ready_after_release", a_in_ready, 1);
    // four words back-to-back fill a frame
    qa.push_back({8'h0F, 8'd4});
    send_a(8'h01, 0); send_a(8'h02, 0); send_a(8'h04, 0); send_a(8'h08, 0);
    check("full_out_valid", a_out_valid, 1);
    check("full_in_ready", a_in_ready, 0);
    drain_a();
    step();
    // flush closes a partial frame that is then held with backpressure
    a_out_ready = 1'b0;
    qa.push_back({8'h30, 8'd2});
    send_a(8'h10, 0); send_a(8'h20, 0);
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", a_out_valid, 1);
      check("hold_in_ready", a_in_ready, 0);
      check("hold_data", a_out_data, 8'h30);
      check("hold_count", a_out_count, 2);
      a_in_valid = 1'b1; a_in_data = 8'hFF; a_flush = 1'(i % 2);
      step();
    end
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
    step();
    check("bubble_out_valid", a_out_valid, 0);
    check("bubble_in_ready", a_in_ready, 1);
    check("hold_queue_empty", qa.size(), 0);
    // word with flush in IDLE, then flush alone in IDLE emits nothing
    qa.push_back({8'h81, 8'd1});
    send_a(8'h81, 1);
    drain_a();
    step();
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("idle_flush_no_valid", a_out_valid, 0);
      step();
    end
    // stale accumulator must not leak into the next frame
    qa.push_back({8'hFF, 8'd1});
    send_a(8'hFF, 1);
    drain_a();
    qa.push_back({8'h01, 8'd4});
    for (int i = 0; i < 4; i++) send_a(8'h01, 0);
    drain_a();
    step();
    // reset mid-frame discards the partial frame
    send_a(8'h55, 0); send_a(8'hAA, 0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_count", a_out_count, 0);
    check("rst_in_ready", a_in_ready, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check("post_rst_no_valid", a_out_valid, 0);
      check("post_rst_in_ready", a_in_ready, 1);
      step();
    end
    qa.push_back({8'h02, 8'd4});
    for (int i = 0; i < 4; i++) send_a(8'h02, 0);
    drain_a();
    // FRAME_LEN=1: every word becomes its own frame under random backpressure
    foreach (words[i]) begin
      qb.push_back({words[i], 8'd1});
      send_b(words[i]);
    end
    b_out_ready = 1'b1;
    for (int n = 0; n < 50 && qb.size() != 0; n++) step();
    check("b_all_delivered", qb.size(), 0);
    check("a_all_delivered", qa.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
